// File: rtl/spi_bram_porta_arb.sv
// Port-A arbiter for the SPI buffer RAM: round-robin between the SPI RX engine (req0)
// and the host/config side (req1), with locked bursts and per-requester tagged read responses.
module spi_bram_porta_arb #(
  parameter int ADDR_W   = 11,
  parameter int DATA_W   = 8,
  parameter int RD_LAT   = 1,
  parameter int LOCK_MAX = 16
) (
  input  logic              clka0,
  input  logic              rstn,
  input  logic              req0_valid,
  input  logic              req0_we,
  input  logic              req0_lock,
  input  logic [ADDR_W-1:0] req0_addr,
  input  logic [DATA_W-1:0] req0_wdata,
  output logic              req0_ready,
  input  logic              req1_valid,
  input  logic              req1_we,
  input  logic              req1_lock,
  input  logic [ADDR_W-1:0] req1_addr,
  input  logic [DATA_W-1:0] req1_wdata,
  output logic              req1_ready,
  output logic              rsp0_valid,
  output logic [DATA_W-1:0] rsp0_rdata,
  output logic              rsp1_valid,
  output logic [DATA_W-1:0] rsp1_rdata,
  output logic              ena,
  output logic              wea,
  output logic [ADDR_W-1:0] addra,
  output logic [DATA_W-1:0] dina,
  input  logic [DATA_W-1:0] douta,
  output logic [1:0]        owner
);

  localparam int CNT_W = $clog2(LOCK_MAX + 1);

  // Encoding doubles as the owner debug value.
  typedef enum logic [1:0] {
    IDLE = 2'b00,
    OWN0 = 2'b01,
    OWN1 = 2'b10
  } state_t;

  state_t             state;
  logic               last_grant;
  logic [CNT_W-1:0]   lock_cnt;
  logic               acc0, acc1, acc, acc_we, acc_lock;
  logic [RD_LAT-1:0]  pipe_v;
  logic [RD_LAT-1:0]  pipe_id;
  logic [DATA_W-1:0]  hold0, hold1;

  // Handshake: a beat transfers on a cycle where reqN_valid & reqN_ready are both high;
  // ready is never raised for an invalid requester and at most one ready is high per cycle.
  always_comb begin
    req0_ready = 1'b0;
    req1_ready = 1'b0;
    if (rstn) begin
      case (state)
        IDLE: begin
          if (req0_valid && req1_valid) begin
            req0_ready = last_grant;
            req1_ready = !last_grant;
          end else begin
            req0_ready = req0_valid;
            req1_ready = req1_valid;
          end
        end
        OWN0:    req0_ready = req0_valid;
        OWN1:    req1_ready = req1_valid;
        default: ;
      endcase
    end
  end

  assign acc0     = req0_ready;
  assign acc1     = req1_ready;
  assign acc      = acc0 | acc1;
  assign acc_we   = acc0 ? req0_we   : req1_we;
  assign acc_lock = acc0 ? req0_lock : req1_lock;

  assign ena   = acc;
  assign wea   = acc & acc_we;
  assign addra = acc0 ? req0_addr  : (acc1 ? req1_addr  : '0);
  assign dina  = acc0 ? req0_wdata : (acc1 ? req1_wdata : '0);
  assign owner = state;

  always_ff @(posedge clka0 or negedge rstn) begin
    if (!rstn) begin
      state      <= IDLE;
      last_grant <= 1'b1;
      lock_cnt   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (acc) begin
            last_grant <= acc1;
            if (acc_lock) begin
              state    <= acc1 ? OWN1 : OWN0;
              lock_cnt <= CNT_W'(1);
            end
          end
        end
        OWN0, OWN1: begin
          if (acc) begin
            // This beat either drops lock or is the LOCK_MAX-th one: hand the peer first turn.
            if (!acc_lock || lock_cnt == CNT_W'(LOCK_MAX - 1)) begin
              state      <= IDLE;
              lock_cnt   <= '0;
              last_grant <= (state == OWN1);
            end else begin
              lock_cnt <= lock_cnt + CNT_W'(1);
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Read tag pipeline tracks RAM latency; the tail entry lines up with douta.
  always_ff @(posedge clka0 or negedge rstn) begin
    if (!rstn) begin
      pipe_v  <= '0;
      pipe_id <= '0;
    end else begin
      pipe_v[0]  <= acc & !acc_we;
      pipe_id[0] <= acc1;
      for (int i = 1; i < RD_LAT; i++) begin
        pipe_v[i]  <= pipe_v[i-1];
        pipe_id[i] <= pipe_id[i-1];
      end
    end
  end

  assign rsp0_valid = pipe_v[RD_LAT-1] & !pipe_id[RD_LAT-1];
  assign rsp1_valid = pipe_v[RD_LAT-1] &  pipe_id[RD_LAT-1];
  assign rsp0_rdata = rsp0_valid ? douta : hold0;
  assign rsp1_rdata = rsp1_valid ? douta : hold1;

  always_ff @(posedge clka0 or negedge rstn) begin
    if (!rstn) begin
      hold0 <= '0;
      hold1 <= '0;
    end else begin
      if (rsp0_valid) hold0 <= douta;
      if (rsp1_valid) hold1 <= douta;
    end
  end

endmodule
